ghost_move_scheduler: RTL and testbench

- Sequences the four ghost target/next-location datapaths once per game tick.
- Time-multiplexes the single maze-RAM read port between ghosts: fetches the 4 surrounding-block rows each ghost requests, presents them on a shared bus, then commits that ghost's next position.
- Owns the registered ghost position state consumed by the renderer and the collision logic.
- Sits between the game-tick generator, the maze RAM and the per-ghost behaviour modules.

---
 rtl/ghost_pkg.sv | 30 +++
 rtl/maze_read_port_mux.sv | 44 ++++
 rtl/ghost_move_scheduler.sv | 144 ++++++++++++++
 tb/tb_ghost_move_scheduler.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost move scheduler and its maze read port mux.
package ghost_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        COMMIT,
        FINISH
    } sched_state_t;

    localparam int MAZE_COLS  = 32;
    localparam int POS_W      = 10;
    localparam int ROW_ADDR_W = 5;
    localparam int ROW_W      = 32;
    localparam int NUM_DIRS   = 4;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    // Blinky, Pinky, Inky, Clyde home tiles (row*32+col)
    localparam logic [POS_W-1:0] GHOST_START_POS [4] = '{10'h1AF, 10'h1CF, 10'h1CD, 10'h1D1};

    function automatic logic [POS_W-1:0] start_pos(input int i);
        return GHOST_START_POS[i % 4];
    endfunction

endpackage

// File: rtl/maze_read_port_mux.sv
// Selects the requested maze row address for the active ghost/direction and captures
// returned RAM data (one cycle read latency) into the shared surround_data rows.
module maze_read_port_mux
    import ghost_pkg::*;
#(
    parameter int NUM_GHOSTS = 4,
    parameter int GW         = 2
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_GHOSTS*NUM_DIRS*ROW_ADDR_W-1:0] ghost_addr,
    input  logic [GW-1:0]                            sel_g,
    input  logic [1:0]                               sel_k,
    output logic [ROW_ADDR_W-1:0]                    rd_addr,
    input  logic                                     rd_issue,
    input  logic [1:0]                               rd_idx,
    input  logic [ROW_W-1:0]                         mem_rdata,
    output logic [NUM_DIRS*ROW_W-1:0]                surround_data
);

    logic             pend;
    logic [1:0]       pidx;
    logic [ROW_W-1:0] rows_q [NUM_DIRS];

    assign rd_addr = ghost_addr[(int'(sel_g) * NUM_DIRS + int'(sel_k)) * ROW_ADDR_W +: ROW_ADDR_W];

    // A read issued this cycle returns next cycle; remember which row it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= 1'b0;
            pidx <= 2'd0;
            for (int d = 0; d < NUM_DIRS; d++) rows_q[d] <= '0;
        end else begin
            pend <= rd_issue;
            pidx <= rd_idx;
            if (pend) rows_q[pidx] <= mem_rdata;
        end
    end

    for (genvar d = 0; d < NUM_DIRS; d++) begin : g_rows
        assign surround_data[d*ROW_W +: ROW_W] = rows_q[d];
    end

endmodule

// File: rtl/ghost_move_scheduler.sv
// Per-tick sweep over all ghosts: fetch 4 surrounding maze rows, present them, commit next
// position. Optional release staggering is enabled with the GHOST_STAGGER_EN macro.
module ghost_move_scheduler
    import ghost_pkg::*;
#(
    parameter int NUM_GHOSTS    = 4,
    parameter int RELEASE_TICKS = 8
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      tick,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      overrun,
    input  logic [NUM_GHOSTS*NUM_DIRS*ROW_ADDR_W-1:0] ghost_addr,
    input  logic [NUM_GHOSTS*POS_W-1:0]               ghost_next_pos,
    output logic [NUM_DIRS*ROW_W-1:0]                 surround_data,
    output logic [NUM_GHOSTS-1:0]                     ghost_sel,
    output logic [NUM_GHOSTS*POS_W-1:0]               ghost_pos,
    output logic                                      mem_rd_en,
    output logic [ROW_ADDR_W-1:0]                     mem_addr,
    input  logic [ROW_W-1:0]                          mem_rdata
);

    localparam int GW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;

    sched_state_t          state;
    logic [GW-1:0]         g;
    logic [1:0]            k;
    logic [GW-1:0]         ag;
    logic [1:0]            ak;
    logic [ROW_ADDR_W-1:0] sel_addr;
    logic [POS_W-1:0]      pos_q [NUM_GHOSTS];
    logic                  eligible;

`ifdef GHOST_STAGGER_EN
    logic [15:0] rel_cnt;
    // Compared before this sweep's increment: ghost i first moves on tick i*RELEASE_TICKS+1.
    assign eligible = (int'(rel_cnt) >= int'(g) * RELEASE_TICKS);
`else
    assign eligible = 1'b1;
`endif

    // Indices of the read to issue on the next cycle.
    always_comb begin
        ag = g;
        ak = k + 2'd1;
        if (state == IDLE) begin
            ag = '0;
            ak = 2'd0;
        end else if (state == COMMIT) begin
            ag = g + GW'(1);
            ak = 2'd0;
        end
    end

    maze_read_port_mux #(
        .NUM_GHOSTS(NUM_GHOSTS),
        .GW        (GW)
    ) u_mux (
        .clk          (clk),
        .reset        (reset),
        .ghost_addr   (ghost_addr),
        .sel_g        (ag),
        .sel_k        (ak),
        .rd_addr      (sel_addr),
        .rd_issue     (mem_rd_en),
        .rd_idx       (k),
        .mem_rdata    (mem_rdata),
        .surround_data(surround_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            g         <= '0;
            k         <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            ghost_sel <= '0;
            for (int i = 0; i < NUM_GHOSTS; i++) pos_q[i] <= start_pos(i);
`ifdef GHOST_STAGGER_EN
            rel_cnt   <= 16'd0;
`endif
        end else begin
            done <= 1'b0;
            if (tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state     <= FETCH;
                        g         <= '0;
                        k         <= 2'd0;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= sel_addr;
                        ghost_sel <= NUM_GHOSTS'(1) << ag;
                    end
                end
                FETCH: begin
                    if (k == 2'd3) begin
                        state     <= DRAIN;
                        mem_rd_en <= 1'b0;
                    end else begin
                        k        <= k + 2'd1;
                        mem_addr <= sel_addr;
                    end
                end
                DRAIN: state <= COMMIT;
                COMMIT: begin
                    if (eligible) pos_q[g] <= ghost_next_pos[int'(g)*POS_W +: POS_W];
                    if (g == GW'(NUM_GHOSTS - 1)) begin
                        state     <= FINISH;
                        ghost_sel <= '0;
                        done      <= 1'b1;
                    end else begin
                        state     <= FETCH;
                        g         <= ag;
                        k         <= 2'd0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= sel_addr;
                        ghost_sel <= NUM_GHOSTS'(1) << ag;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
`ifdef GHOST_STAGGER_EN
                    if (rel_cnt != 16'hFFFF) rel_cnt <= rel_cnt + 16'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_GHOSTS; i++) begin : g_pos
        assign ghost_pos[i*POS_W +: POS_W] = pos_q[i];
    end

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// Self-checking bench for ghost_move_scheduler (default build, staggering disabled).
module tb_ghost_move_scheduler;
    import ghost_pkg::*;

    localparam int NG = 4;

    logic            clk;
    logic            reset;
    logic            tick;
    logic            busy;
    logic            done;
    logic            overrun;
    logic [NG*20-1:0] ghost_addr;
    logic [NG*10-1:0] ghost_next_pos;
    logic [127:0]    surround_data;
    logic [NG-1:0]   ghost_sel;
    logic [NG*10-1:0] ghost_pos;
    logic            mem_rd_en;
    logic [4:0]      mem_addr;
    logic [31:0]     mem_rdata;

    int checks = 0;
    int fails  = 0;

    logic [4:0]   exp_addr_q[$];
    logic [127:0] exp_sur_q[$];
    logic [4:0]   mon_addr;

    ghost_move_scheduler #(.NUM_GHOSTS(NG), .RELEASE_TICKS(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun),
        .ghost_addr    (ghost_addr),
        .ghost_next_pos(ghost_next_pos),
        .surround_data (surround_data),
        .ghost_sel     (ghost_sel),
        .ghost_pos     (ghost_pos),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Maze RAM model: row r reads as r*0x01010101, garbage when not enabled
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= {4{3'b000, mem_addr}};
        else mem_rdata <= $urandom;
    end

    // Address scoreboard: every issued read must match the next expected row request
    always @(negedge clk) begin
        if (!reset && mem_rd_en) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                fails++;
                $display("FAIL mem_addr unexpected read got=%0d required=no read", mem_addr);
            end else begin
                mon_addr = exp_addr_q.pop_front();
                if (mem_addr !== mon_addr) begin
                    fails++;
                    $display("FAIL mem_addr got=%0d required=%0d", mem_addr, mon_addr);
                end
            end
        end
    end

    // Driver tasks
    task automatic load_addrs();
        for (int i = 0; i < NG * 4; i++) ghost_addr[i*5 +: 5] = 5'($urandom_range(0, 31));
    endtask

    task automatic set_next(input logic [9:0] base);
        for (int i = 0; i < NG; i++) ghost_next_pos[i*10 +: 10] = base + 10'(i);
    endtask

    task automatic push_sweep();
        logic [127:0] s;
        logic [4:0]   a;
        for (int g = 0; g < NG; g++) begin
            s = '0;
            for (int d = 0; d < 4; d++) begin
                a = ghost_addr[(g*4+d)*5 +: 5];
                exp_addr_q.push_back(a);
                s[d*32 +: 32] = {4{3'b000, a}};
            end
            exp_sur_q.push_back(s);
        end
    endtask

    task automatic test_reset();
        int rd_seen = 0;
        tick = 1'b0;
        reset = 1'b1;
        load_addrs();
        set_next(10'h100);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_rd_en !== 1'b0) rd_seen++;
            checks++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_busy c=%0d got=%b required=0", c, busy);
            end
        end
        checks++;
        if (rd_seen != 0) begin
            fails++;
            $display("FAIL reset_rd_en got=%0d reads required=0", rd_seen);
        end
        checks++;
        if ({done, overrun, ghost_sel, mem_addr} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got=%b/%b/%b/%0d required=all zero", done, overrun, ghost_sel, mem_addr);
        end
        checks++;
        if (surround_data !== '0) begin
            fails++;
            $display("FAIL reset_surround got=%h required=0", surround_data);
        end
        for (int i = 0; i < NG; i++) begin
            checks++;
            if (ghost_pos[i*10 +: 10] !== GHOST_START_POS[i]) begin
                fails++;
                $display("FAIL reset_pos[%0d] got=%h required=%h", i, ghost_pos[i*10 +: 10], GHOST_START_POS[i]);
            end
        end
    endtask

    task automatic test_single_tick();
        logic [127:0]  es;
        logic [NG-1:0] esel;
        load_addrs();
        set_next(10'h100);
        push_sweep();
        @(negedge clk);
        tick = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            tick = 1'b0;
            checks++;
            if (done !== (c == 25)) begin
                fails++;
                $display("FAIL single_done c=%0d got=%b required=%b", c, done, (c == 25));
            end
            checks++;
            if (busy !== (c <= 25)) begin
                fails++;
                $display("FAIL single_busy c=%0d got=%b required=%b", c, busy, (c <= 25));
            end
            if (c % 6 == 0 && c <= 24) begin
                es = (exp_sur_q.size() > 0) ? exp_sur_q.pop_front() : 'x;
                esel = '0;
                esel[c/6-1] = 1'b1;
                checks++;
                if (surround_data !== es) begin
                    fails++;
                    $display("FAIL single_surround g=%0d got=%h required=%h", c/6-1, surround_data, es);
                end
                checks++;
                if (ghost_sel !== esel) begin
                    fails++;
                    $display("FAIL single_sel g=%0d got=%b required=%b", c/6-1, ghost_sel, esel);
                end
            end
        end
        for (int i = 0; i < NG; i++) begin
            checks++;
            if (ghost_pos[i*10 +: 10] !== 10'(10'h100 + i)) begin
                fails++;
                $display("FAIL single_pos[%0d] got=%h required=%h", i, ghost_pos[i*10 +: 10], 10'h100 + i);
            end
        end
    endtask

    task automatic test_overrun();
        int dn = 0;
        load_addrs();
        set_next(10'h180);
        push_sweep();
        @(negedge clk);
        tick = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            tick = (c == 5);
            if (done === 1'b1) dn++;
            if (c % 6 == 0 && c <= 24 && exp_sur_q.size() > 0) void'(exp_sur_q.pop_front());
            checks++;
            if (overrun !== (c >= 6)) begin
                fails++;
                $display("FAIL overrun_flag c=%0d got=%b required=%b", c, overrun, (c >= 6));
            end
        end
        checks++;
        if (dn != 1) begin
            fails++;
            $display("FAIL overrun_done_count got=%0d required=1", dn);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_sticky got=%b required=1", overrun);
        end
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        logic [127:0] es;
        load_addrs();
        set_next(10'h300);
        push_sweep();
        @(negedge clk);
        tick = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            tick = 1'b0;
        end
        checks++;
        if (ghost_pos[9:0] !== 10'h300) begin
            fails++;
            $display("FAIL mid_precommit got=%h required=300", ghost_pos[9:0]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, overrun, mem_rd_en, ghost_sel} !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs got=%b%b%b%b/%b required=all zero", busy, done, overrun, mem_rd_en, ghost_sel);
        end
        for (int i = 0; i < NG; i++) begin
            checks++;
            if (ghost_pos[i*10 +: 10] !== GHOST_START_POS[i]) begin
                fails++;
                $display("FAIL mid_pos[%0d] got=%h required=%h", i, ghost_pos[i*10 +: 10], GHOST_START_POS[i]);
            end
        end
        exp_addr_q.delete();
        exp_sur_q.delete();
        // Tick coincident with reset release must start a sweep
        @(negedge clk);
        push_sweep();
        reset = 1'b0;
        tick = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            tick = 1'b0;
            if (done === 1'b1) dn++;
            if (c == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    fails++;
                    $display("FAIL mid_release_tick got=%b required=1", busy);
                end
            end
            if (c % 6 == 0 && c <= 24) begin
                es = (exp_sur_q.size() > 0) ? exp_sur_q.pop_front() : 'x;
                checks++;
                if (surround_data !== es) begin
                    fails++;
                    $display("FAIL mid_surround g=%0d got=%h required=%h", c/6-1, surround_data, es);
                end
            end
        end
        checks++;
        if (dn != 1) begin
            fails++;
            $display("FAIL mid_done_count got=%0d required=1", dn);
        end
        for (int i = 0; i < NG; i++) begin
            checks++;
            if (ghost_pos[i*10 +: 10] !== 10'(10'h300 + i)) begin
                fails++;
                $display("FAIL mid_final_pos[%0d] got=%h required=%h", i, ghost_pos[i*10 +: 10], 10'h300 + i);
            end
        end
    endtask

    task automatic test_back_to_back();
        int rel;
        logic [127:0]  es;
        logic [NG-1:0] esel;
        load_addrs();
        set_next(10'h200);
        push_sweep();
        push_sweep();
        @(negedge clk);
        tick = 1'b1;
        for (int c = 1; c <= 52; c++) begin
            @(negedge clk);
            tick = 1'b0;
            rel = (c <= 26) ? c : c - 26;
            esel = '0;
            if (rel <= 24) esel[(rel-1)/6] = 1'b1;
            checks++;
            if (ghost_sel !== esel) begin
                fails++;
                $display("FAIL b2b_sel c=%0d got=%b required=%b", c, ghost_sel, esel);
            end
            checks++;
            if (busy !== (rel <= 25) || done !== (rel == 25)) begin
                fails++;
                $display("FAIL b2b_busy_done c=%0d got=%b%b required=%b%b", c, busy, done, (rel <= 25), (rel == 25));
            end
            if (rel % 6 == 0 && rel <= 24) begin
                es = (exp_sur_q.size() > 0) ? exp_sur_q.pop_front() : 'x;
                checks++;
                if (surround_data !== es) begin
                    fails++;
                    $display("FAIL b2b_surround c=%0d got=%h required=%h", c, surround_data, es);
                end
            end
            if (c == 26) tick = 1'b1;
        end
        checks++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL b2b_overrun got=%b required=0", overrun);
        end
        for (int i = 0; i < NG; i++) begin
            checks++;
            if (ghost_pos[i*10 +: 10] !== 10'(10'h200 + i)) begin
                fails++;
                $display("FAIL b2b_pos[%0d] got=%h required=%h", i, ghost_pos[i*10 +: 10], 10'h200 + i);
            end
        end
        checks++;
        if (exp_addr_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_reads_left got=%0d required=0", exp_addr_q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        tick = 1'b0;
        ghost_addr = '0;
        ghost_next_pos = '0;
        test_reset();
        test_single_tick();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
